pll_lock_ctrl: RTL and testbench



---
 rtl/pll_lock_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: core-clock PLL sequencer.
// Pulses the PLL reset, debounces the synchronised lock, releases the core
// reset, recovers from lock loss or lock timeout, and retunes the PLL through
// the pll_reconfig management port on request. Every output is a register.
module pll_lock_ctrl #(
  parameter int RESET_CYCLES   = 16,
  parameter int LOCK_CYCLES    = 1024,
  parameter int RELOCK_TIMEOUT = 65536
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        pll_locked,
  output logic        pll_rst,
  output logic        core_reset,
  output logic        ready,
  output logic        busy,
  output logic [7:0]  relock_count,
  input  logic        cfg_req,
  output logic        cfg_ack,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c0,
  input  logic [31:0] cfg_k,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest
);

  // Each counter only has to reach PARAM-1, so $clog2(PARAM) bits never wrap.
  localparam int RST_W  = (RESET_CYCLES   > 1) ? $clog2(RESET_CYCLES)   : 1;
  localparam int LOCK_W = (LOCK_CYCLES    > 1) ? $clog2(LOCK_CYCLES)    : 1;
  localparam int TO_W   = (RELOCK_TIMEOUT > 1) ? $clog2(RELOCK_TIMEOUT) : 1;

  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESET_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RELOCK_TIMEOUT - 1);

  localparam logic [1:0] ST_RESET_PLL = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_CFG_WR    = 2'd3;

  localparam logic [2:0] IDX_LAST = 3'd5;

  logic              lk_meta_r, lk_r;
  logic [1:0]        state_r, state_s;
  logic [RST_W-1:0]  rst_cnt_r, rst_cnt_s;
  logic [LOCK_W-1:0] lock_cnt_r, lock_cnt_s;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_s;
  logic [2:0]        idx_r, idx_s;
  logic              wr_s, ack_s, relock_inc_s, latch_s;
  logic [17:0]       cfg_n_r, cfg_m_r, cfg_c0_r;
  logic [31:0]       cfg_k_r;

  logic              pll_rst_r, core_reset_r, ready_r, busy_r, cfg_ack_r, mgmt_write_r;
  logic [7:0]        relock_count_r;
  logic [5:0]        mgmt_address_r;
  logic [31:0]       mgmt_writedata_r;

  // Register map of the reconfiguration sequence, indexed by write number.
  function automatic logic [5:0] wr_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    wr_addr = 6'h00;  // mode register: waitrequest mode
      3'd1:    wr_addr = 6'h03;  // N counter
      3'd2:    wr_addr = 6'h04;  // M counter
      3'd3:    wr_addr = 6'h07;  // fractional M (K)
      3'd4:    wr_addr = 6'h05;  // C counter, select C0
      3'd5:    wr_addr = 6'h02;  // start
      default: wr_addr = 6'h00;
    endcase
  endfunction

  // Write data of the reconfiguration sequence, from the latched settings.
  function automatic logic [31:0] wr_data(input logic [2:0] idx, input logic [17:0] n,
                                          input logic [17:0] m, input logic [31:0] k,
                                          input logic [17:0] c0);
    case (idx)
      3'd1:    wr_data = {14'd0, n};
      3'd2:    wr_data = {14'd0, m};
      3'd3:    wr_data = k;
      3'd4:    wr_data = {9'd0, 5'd0, c0};
      default: wr_data = 32'h0000_0000;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous PLL lock output.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lk_meta_r <= 1'b0;
      lk_r      <= 1'b0;
    end else begin
      lk_meta_r <= pll_locked;
      lk_r      <= lk_meta_r;
    end
  end

  // Sequencer next-state, counter and management-write decisions.
  always_comb begin
    state_s      = state_r;
    rst_cnt_s    = rst_cnt_r;
    lock_cnt_s   = lock_cnt_r;
    to_cnt_s     = to_cnt_r;
    idx_s        = idx_r;
    wr_s         = mgmt_write_r;
    ack_s        = 1'b0;
    relock_inc_s = 1'b0;
    latch_s      = 1'b0;
    case (state_r)
      ST_RESET_PLL: begin
        if (rst_cnt_r == RST_LAST) begin
          state_s    = ST_WAIT_LOCK;
          rst_cnt_s  = '0;
          lock_cnt_s = '0;
          to_cnt_s   = '0;
        end else begin
          rst_cnt_s = rst_cnt_r + RST_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // A stable lock wins over a timeout landing on the same cycle.
        if (lk_r && (lock_cnt_r == LOCK_LAST)) begin
          state_s    = ST_RUN;
          lock_cnt_s = '0;
          to_cnt_s   = '0;
        end else if (to_cnt_r == TO_LAST) begin
          state_s      = ST_RESET_PLL;
          relock_inc_s = 1'b1;
          rst_cnt_s    = '0;
          lock_cnt_s   = '0;
          to_cnt_s     = '0;
        end else begin
          to_cnt_s = to_cnt_r + TO_W'(1);
          if (lk_r) begin
            lock_cnt_s = lock_cnt_r + LOCK_W'(1);
          end else begin
            lock_cnt_s = '0;
          end
        end
      end
      ST_RUN: begin
        // Lock loss is checked first so it beats a simultaneous request.
        if (!lk_r) begin
          state_s      = ST_WAIT_LOCK;
          relock_inc_s = 1'b1;
          lock_cnt_s   = '0;
          to_cnt_s     = '0;
        end else if (cfg_req) begin
          state_s = ST_CFG_WR;
          ack_s   = 1'b1;
          latch_s = 1'b1;
          idx_s   = 3'd0;
          wr_s    = 1'b0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_CFG_WR: begin
        // First cycle is idle (settings just latched); then one write per accept.
        if (!mgmt_write_r) begin
          wr_s = 1'b1;
        end else if (!mgmt_waitrequest) begin
          if (idx_r == IDX_LAST) begin
            wr_s       = 1'b0;
            idx_s      = 3'd0;
            state_s    = ST_WAIT_LOCK;
            lock_cnt_s = '0;
            to_cnt_s   = '0;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          wr_s = 1'b1;
        end
      end
      default: begin
        state_s   = ST_RESET_PLL;
        rst_cnt_s = '0;
        wr_s      = 1'b0;
      end
    endcase
  end

  // State, counters, latched settings and registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_r          <= ST_RESET_PLL;
      rst_cnt_r        <= '0;
      lock_cnt_r       <= '0;
      to_cnt_r         <= '0;
      idx_r            <= 3'd0;
      cfg_n_r          <= 18'd0;
      cfg_m_r          <= 18'd0;
      cfg_c0_r         <= 18'd0;
      cfg_k_r          <= 32'd0;
      pll_rst_r        <= 1'b1;
      core_reset_r     <= 1'b1;
      ready_r          <= 1'b0;
      busy_r           <= 1'b1;
      cfg_ack_r        <= 1'b0;
      mgmt_write_r     <= 1'b0;
      mgmt_address_r   <= 6'h00;
      mgmt_writedata_r <= 32'h0000_0000;
      relock_count_r   <= 8'd0;
    end else begin
      state_r      <= state_s;
      rst_cnt_r    <= rst_cnt_s;
      lock_cnt_r   <= lock_cnt_s;
      to_cnt_r     <= to_cnt_s;
      idx_r        <= idx_s;
      if (latch_s) begin
        cfg_n_r  <= cfg_n;
        cfg_m_r  <= cfg_m;
        cfg_c0_r <= cfg_c0;
        cfg_k_r  <= cfg_k;
      end
      pll_rst_r        <= (state_s == ST_RESET_PLL);
      core_reset_r     <= (state_s != ST_RUN);
      ready_r          <= (state_s == ST_RUN);
      busy_r           <= (state_s != ST_RUN);
      cfg_ack_r        <= ack_s;
      mgmt_write_r     <= wr_s;
      mgmt_address_r   <= wr_s ? wr_addr(idx_s) : 6'h00;
      mgmt_writedata_r <= wr_s ? wr_data(idx_s, cfg_n_r, cfg_m_r, cfg_k_r, cfg_c0_r)
                               : 32'h0000_0000;
      if (relock_inc_s && (relock_count_r != 8'hFF)) begin
        relock_count_r <= relock_count_r + 8'd1;
      end
    end
  end

  assign pll_rst        = pll_rst_r;
  assign core_reset     = core_reset_r;
  assign ready          = ready_r;
  assign busy           = busy_r;
  assign relock_count   = relock_count_r;
  assign cfg_ack        = cfg_ack_r;
  assign mgmt_address   = mgmt_address_r;
  assign mgmt_write     = mgmt_write_r;
  assign mgmt_writedata = mgmt_writedata_r;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Self-checking bench for pll_lock_ctrl: directed power-up, glitch, loss,
// reconfiguration, async reset and timeout scenarios plus a randomized
// stretch, all compared every cycle against a timestamp-based reference.
module tb_pll_lock_ctrl;

  localparam int RC = 16;
  localparam int LC = 32;
  localparam int RT = 128;

  logic        refclk = 1'b0;
  logic        rst, pll_locked, cfg_req, mgmt_waitrequest;
  logic        pll_rst, core_reset, ready, busy, cfg_ack, mgmt_write;
  logic [7:0]  relock_count;
  logic [17:0] cfg_n, cfg_m, cfg_c0;
  logic [31:0] cfg_k, mgmt_writedata;
  logic [5:0]  mgmt_address;

  always #10 refclk = ~refclk;

  pll_lock_ctrl #(.RESET_CYCLES(RC), .LOCK_CYCLES(LC), .RELOCK_TIMEOUT(RT)) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .core_reset(core_reset), .ready(ready), .busy(busy), .relock_count(relock_count),
    .cfg_req(cfg_req), .cfg_ack(cfg_ack), .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c0(cfg_c0),
    .cfg_k(cfg_k), .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: mode plus time spent in it, lock run length, write queue.
  typedef struct packed { logic [5:0] a; logic [31:0] d; } wr_t;
  int          m_mode;   // 0 reset pulse, 1 waiting for lock, 2 running, 3 retuning
  int          m_el;     // edges spent in the current mode
  int          m_run;    // consecutive edges with lock seen high while waiting
  int          m_relock;
  bit          m_ack, m_wr;
  logic [5:0]  m_addr;
  logic [31:0] m_data;
  bit          s0, s1;   // pll_locked as seen one and two edges ago
  wr_t         m_q[$];
  bit          rec;
  logic [5:0]  obs_a[$];
  logic [31:0] obs_d[$];

  task automatic m_enter(input int m);
    m_mode = m; m_el = 0; m_run = 0;
  endtask

  task automatic m_bump();
    if (m_relock < 255) m_relock++;
  endtask

  task automatic model_reset();
    m_enter(0); m_relock = 0; m_ack = 0; m_wr = 0; m_addr = '0; m_data = '0;
    s0 = 0; s1 = 0; m_q.delete();
  endtask

  task automatic model_edge();
    bit lk;
    lk = s1; s1 = s0; s0 = pll_locked;
    m_ack = 0;
    case (m_mode)
      0: begin m_el++; if (m_el == RC) m_enter(1); end
      1: begin
        m_el++;
        m_run = lk ? m_run + 1 : 0;
        if (m_run == LC) m_enter(2);
        else if (m_el == RT) begin m_bump(); m_enter(0); end
      end
      2: begin
        if (!lk) begin m_bump(); m_enter(1); end
        else if (cfg_req) begin
          m_ack = 1;
          m_q.delete();
          m_q.push_back('{a: 6'h00, d: 32'h0});
          m_q.push_back('{a: 6'h03, d: {14'd0, cfg_n}});
          m_q.push_back('{a: 6'h04, d: {14'd0, cfg_m}});
          m_q.push_back('{a: 6'h07, d: cfg_k});
          m_q.push_back('{a: 6'h05, d: {14'd0, cfg_c0}});
          m_q.push_back('{a: 6'h02, d: 32'h0});
          m_enter(3);
        end
      end
      3: begin
        if (!m_wr) begin
          m_wr = 1; m_addr = m_q[0].a; m_data = m_q[0].d;
        end else if (!mgmt_waitrequest) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_wr = 0; m_addr = '0; m_data = '0; m_enter(1);
          end else begin
            m_addr = m_q[0].a; m_data = m_q[0].d;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare();
    chk("ctrl", 64'({pll_rst, core_reset, ready, busy, cfg_ack, mgmt_write}),
        64'({m_mode == 0, m_mode != 2, m_mode == 2, m_mode != 2, m_ack, m_wr}));
    chk("relock", 64'(relock_count), 64'(m_relock));
    chk("mgmt", 64'({mgmt_address, mgmt_writedata}), 64'({m_addr, m_data}));
  endtask

  task automatic step();
    logic done_w;
    logic [5:0] a;
    logic [31:0] d;
    done_w = mgmt_write && !mgmt_waitrequest; a = mgmt_address; d = mgmt_writedata;
    @(posedge refclk);
    if (rec && done_w && !rst) begin obs_a.push_back(a); obs_d.push_back(d); end
    #1;
    if (rst) model_reset(); else model_edge();
    compare();
  endtask

  logic [5:0]  exp_a [6];
  logic [31:0] exp_d [6];

  initial begin
    int n, stall, rel0;
    exp_a = '{6'h00, 6'h03, 6'h04, 6'h07, 6'h05, 6'h02};
    exp_d = '{32'h0, 32'h20303, 32'h808, 32'h1234_5678, 32'h10302, 32'h0};
    rst = 1; pll_locked = 0; cfg_req = 0; mgmt_waitrequest = 0; rec = 0;
    cfg_n = '0; cfg_m = '0; cfg_c0 = '0; cfg_k = '0;
    model_reset();
    repeat (5) step();

    // Power-up: reset pulse width, then lock latency.
    rst = 0; n = 0;
    do begin step(); n++; end while (pll_rst && n < 100);
    chk("prst_fall_edge", 64'(n), 64'(RC));
    repeat (40 - n) step();
    pll_locked = 1; n = 0;
    do begin step(); n++; end while (!ready && n < 200);
    chk("lock_latency", 64'(n), 64'(2 + LC));
    chk("relock_pwrup", 64'(relock_count), 64'd0);

    // Loss in RUN, then a one-cycle glitch mid-debounce.
    pll_locked = 0; n = 0;
    do begin step(); n++; end while (!core_reset && n < 20);
    chk("loss_latency", 64'(n), 64'd3);
    chk("relock_loss", 64'(relock_count), 64'd1);
    repeat (5) step();
    pll_locked = 1; repeat (2 + 15) step();
    pll_locked = 0; step();
    pll_locked = 1; n = 0;
    do begin step(); n++; end while (!ready && n < 200);
    chk("glitch_latency", 64'(n), 64'(2 + LC));

    // Randomized lock drops, requests and stalls.
    for (int i = 0; i < 600; i++) begin
      if (pll_locked) pll_locked = ($urandom_range(0, 99) >= 2);
      else pll_locked = ($urandom_range(0, 99) < 40);
      if (cfg_req && m_ack) cfg_req = 0;
      else if (!cfg_req && $urandom_range(0, 99) < 5) begin
        cfg_req = 1; cfg_n = 18'($urandom); cfg_m = 18'($urandom);
        cfg_c0 = 18'($urandom); cfg_k = $urandom;
      end
      mgmt_waitrequest = ($urandom_range(0, 3) == 0);
      step();
    end
    pll_locked = 1; mgmt_waitrequest = 0; n = 0;
    while ((cfg_req || m_mode != 2) && n < 400) begin
      if (cfg_req && m_ack) cfg_req = 0;
      step(); n++;
    end
    chk("drain", 64'(n < 400), 64'd1);

    // Directed reconfiguration with a 3-cycle stall on the M write.
    rel0 = m_relock;
    cfg_n = 18'h20303; cfg_m = 18'h00808; cfg_k = 32'h1234_5678; cfg_c0 = 18'h10302;
    cfg_req = 1; rec = 1; stall = 0; n = 0;
    while (n < 60 && m_mode != 1) begin
      if (cfg_req && m_ack) cfg_req = 0;
      if (mgmt_write && mgmt_address == 6'h04 && stall < 3) begin
        mgmt_waitrequest = 1; stall++;
      end else mgmt_waitrequest = 0;
      step(); n++;
    end
    rec = 0; mgmt_waitrequest = 0;
    chk("cfg_cycles", 64'(n), 64'd11);
    chk("cfg_stall", 64'(stall), 64'd3);
    chk("cfg_nwr", 64'(obs_a.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_a.size()) begin
        chk("cfg_addr", 64'(obs_a[i]), 64'(exp_a[i]));
        chk("cfg_data", 64'(obs_d[i]), 64'(exp_d[i]));
      end
    end
    chk("cfg_wait_lock", 64'({ready, core_reset}), 64'd1);
    chk("cfg_relock", 64'(relock_count), 64'(rel0));
    n = 0;
    do begin step(); n++; end while (!ready && n < 200);
    chk("cfg_relock_latency", 64'(n), 64'(LC));

    // Async reset in the middle of the K write.
    cfg_n = 18'($urandom); cfg_m = 18'($urandom); cfg_c0 = 18'($urandom); cfg_k = $urandom;
    cfg_req = 1; n = 0;
    while (!(mgmt_write && mgmt_address == 6'h07) && n < 40) begin
      if (cfg_req && m_ack) cfg_req = 0;
      step(); n++;
    end
    chk("reach_idx3", 64'({mgmt_write, mgmt_address}), 64'({1'b1, 6'h07}));
    rst = 1; #1;
    chk("arst_outs", 64'({pll_rst, core_reset, ready, busy, cfg_ack, mgmt_write, relock_count, mgmt_address}),
        64'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 6'h00}));
    chk("arst_data", 64'(mgmt_writedata), 64'd0);
    model_reset(); cfg_req = 0;
    repeat (3) step();
    rst = 0; n = 0;
    do begin step(); n++; end while (!ready && n < 200);
    chk("restart_latency", 64'(n), 64'(RC + LC));

    // Lock held low: periodic reset pulses and saturating relock count.
    pll_locked = 0; n = 0;
    while (!pll_rst && n < 400) begin step(); n++; end
    n = 0;
    do begin step(); n++; end while (pll_rst && n < 400);
    do begin step(); n++; end while (!pll_rst && n < 400);
    chk("rst_period", 64'(n), 64'(RC + RT));
    n = 0;
    while (relock_count != 8'hFF && n < 45000) begin step(); n++; end
    chk("relock_sat", 64'(relock_count), 64'hFF);
    repeat (300) step();
    chk("relock_hold", 64'(relock_count), 64'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
